regfiletmp_ctrl: RTL



---
 rtl/regfiletmp_ctrl_if.sv | 52 +++++
 rtl/regfiletmp_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/regfiletmp_ctrl_if.sv
// regfiletmp_ctrl_if: dispatch/completion/flush/temp-file/commit signal bundle
// Ports (slave = controller view):
//   dispatch : disp_valid, disp_rd, disp_pc, disp_type in; disp_ready, disp_tag out
//   complete : cmp_valid, cmp_tag, cmp_data in
//   flush    : flush_valid, flush_tag in
//   temp file: rf_data_in, rf_waddr, rf_new_entry, rf_update_entry, rf_rd_addr1 out; rf_data_out1 in
//   commit   : cmt_valid, cmt_rd, cmt_pc, cmt_type, cmt_data out; cmt_ready in
interface regfiletmp_ctrl_if #(parameter int AW = 5);
  logic          disp_valid;
  logic          disp_ready;
  logic [3:0]    disp_rd;
  logic [32:0]   disp_pc;
  logic [1:0]    disp_type;
  logic [AW-1:0] disp_tag;
  logic          cmp_valid;
  logic [AW-1:0] cmp_tag;
  logic          cmp_data;
  logic          flush_valid;
  logic [AW-1:0] flush_tag;
  logic [41:0]   rf_data_in;
  logic [AW-1:0] rf_waddr;
  logic          rf_new_entry;
  logic          rf_update_entry;
  logic [AW-1:0] rf_rd_addr1;
  logic [41:0]   rf_data_out1;
  logic          cmt_valid;
  logic          cmt_ready;
  logic [3:0]    cmt_rd;
  logic [32:0]   cmt_pc;
  logic [1:0]    cmt_type;
  logic          cmt_data;
  modport slave (
    input  disp_valid, disp_rd, disp_pc, disp_type,
    output disp_ready, disp_tag,
    input  cmp_valid, cmp_tag, cmp_data,
    input  flush_valid, flush_tag,
    output rf_data_in, rf_waddr, rf_new_entry, rf_update_entry, rf_rd_addr1,
    input  rf_data_out1,
    output cmt_valid, cmt_rd, cmt_pc, cmt_type, cmt_data,
    input  cmt_ready
  );
  modport master (
    output disp_valid, disp_rd, disp_pc, disp_type,
    input  disp_ready, disp_tag,
    output cmp_valid, cmp_tag, cmp_data,
    output flush_valid, flush_tag,
    input  rf_data_in, rf_waddr, rf_new_entry, rf_update_entry, rf_rd_addr1,
    output rf_data_out1,
    input  cmt_valid, cmt_rd, cmt_pc, cmt_type, cmt_data,
    output cmt_ready
  );
endinterface

// File: rtl/regfiletmp_ctrl.sv
// regfiletmp_ctrl: circular-buffer allocation, completion and in-order commit for the temporary register file
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus          : regfiletmp_ctrl_if.slave (dispatch, completion, flush, temp-file port, commit)
//   o_stall_cnt  : dispatch stall counter
// Optional feature: define REGFILETMP_CTRL_STALL_CNT_EN to build the saturating stall counter;
// otherwise o_stall_cnt is tied to 0.
// Entry layout: rd[41:38] pc[37:5] type[4:3] spec_data[2] spec_valid[1] valid[0]
module regfiletmp_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  regfiletmp_ctrl_if.slave     bus,
  output logic [15:0]          o_stall_cnt
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_head_n;
  logic [AW-1:0] w_tail_n;
  logic [AW:0]   w_count_n;
  logic [AW-1:0] w_off;
  logic          w_ready;
  logic          w_fire;
  logic          w_cmt_valid;
  logic          w_commit;
  logic          w_flush_hit;
  // Completion owns the single write port, so dispatch backs off whenever one is present.
  assign w_ready     = (r_count != FULL) && !bus.cmp_valid && !bus.flush_valid;
  assign w_fire      = bus.disp_valid && w_ready;
  assign w_cmt_valid = (r_count != '0) && bus.rf_data_out1[0] && bus.rf_data_out1[1];
  assign w_commit    = w_cmt_valid && bus.cmt_ready;
  // Distance of the surviving tag from head; only tags inside the live window rewind the tail.
  assign w_off       = bus.flush_tag - r_head;
  assign w_flush_hit = bus.flush_valid && (r_count != '0) && ({1'b0, w_off} < r_count);
  assign bus.disp_ready      = w_ready;
  assign bus.disp_tag        = r_tail;
  assign bus.rf_rd_addr1     = r_head;
  assign bus.rf_new_entry    = w_fire;
  assign bus.rf_update_entry = bus.cmp_valid;
  assign bus.rf_waddr        = bus.cmp_valid ? bus.cmp_tag : r_tail;
  assign bus.rf_data_in      = bus.cmp_valid ? {39'b0, bus.cmp_data, 2'b10} :
                               w_fire        ? {bus.disp_rd, bus.disp_pc, bus.disp_type, 3'b001} :
                                               42'b0;
  assign bus.cmt_valid = w_cmt_valid;
  assign bus.cmt_rd    = bus.rf_data_out1[41:38];
  assign bus.cmt_pc    = bus.rf_data_out1[37:5];
  assign bus.cmt_type  = bus.rf_data_out1[4:3];
  assign bus.cmt_data  = bus.rf_data_out1[2];
  // A commit alongside a flush has already retired the head, so the survivor count drops by one.
  always_comb begin
    w_head_n  = w_commit ? r_head + 1'b1 : r_head;
    w_tail_n  = w_flush_hit ? bus.flush_tag + 1'b1 : w_fire ? r_tail + 1'b1 : r_tail;
    w_count_n = w_flush_hit ? (w_commit ? {1'b0, w_off} : {1'b0, w_off} + 1'b1) :
                r_count + {{AW{1'b0}}, w_fire} - {{AW{1'b0}}, w_commit};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
    end
  end
`ifdef REGFILETMP_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;
  assign w_stall = bus.disp_valid && !w_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'd0;
`endif
endmodule
